univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the 4-bit parallel-in/parallel-out register. Supports hold, shift, rotate, load and clear modes, selected per cycle. Adds an autonomous burst serialiser: one start pulse loads a word, then shifts out WIDTH bits while capturing WIDTH bits from ser_in. Used wherever a parallel register, a SIPO, a PISO or a full-duplex bit-serial link endpoint is needed.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_bit_cnt.sv | 45 ++++
 rtl/univ_shift_reg.sv | 125 ++++++++++++
 tb/tb_univ_shift_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode codes, FSM state
// encoding and burst direction values.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROTL = 3'b100;
   localparam logic [2:0] MODE_ROTR = 3'b101;
   localparam logic [2:0] MODE_CLR  = 3'b110;
   localparam logic [2:0] MODE_ASR  = 3'b111;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_BURST = 1'b1;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_bit_cnt.sv
// Loadable down-counter with clock enable; tc flags that the next decrement
// reaches zero.
module usr_bit_cnt
   import usr_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: load wins over decrement, zero never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = cnt_q;
      end else if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with per-cycle modes and an autonomous burst
// serialiser. Define USR_ARITH_SHIFT_EN to make mode 111 an arithmetic right shift.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] parallel_in,
   input  logic             ser_in,
   input  logic             dir,
   input  logic             start,
   output logic [WIDTH-1:0] parallel_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   logic             state_q, state_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             cnt_load_s, cnt_dec_s, cnt_tc_s;

   usr_bit_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (cnt_load_s),
      .load_val (CNT_W'(WIDTH)),
      .dec      (cnt_dec_s),
      .tc       (cnt_tc_s)
   );

   // state, direction and done registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_LSB_FIRST;
         done_q  <= 1'b0;
         q_q     <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         q_q     <= q_d;
      end
   end

   // FSM next state; done is not gated by en so it always self-clears
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      done_d     = 1'b0;
      cnt_load_s = 1'b0;
      cnt_dec_s  = 1'b0;
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d    = ST_BURST;
                  dir_d      = dir;
                  cnt_load_s = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_BURST: begin
               cnt_dec_s = 1'b1;
               if (cnt_tc_s) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_BURST;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // datapath: burst shifting overrides the per-cycle mode
   always_comb begin
      q_d = q_q;
      if (!en) begin
         q_d = q_q;
      end else if (state_q == ST_BURST) begin
         if (dir_q == DIR_MSB_FIRST) begin
            q_d = {q_q[WIDTH-2:0], ser_in};
         end else begin
            q_d = {ser_in, q_q[WIDTH-1:1]};
         end
      end else if (start) begin
         q_d = parallel_in;
      end else begin
         case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], ser_in};
            MODE_SHR:  q_d = {ser_in, q_q[WIDTH-1:1]};
            MODE_LOAD: q_d = parallel_in;
            MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_CLR:  q_d = {WIDTH{1'b0}};
`ifdef USR_ARITH_SHIFT_EN
            MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
`else
            MODE_ASR:  q_d = q_q;
`endif
            default:   q_d = q_q;
         endcase
      end
   end

   assign parallel_out = q_q;
   assign ser_out      = (dir_q == DIR_MSB_FIRST) ? q_q[WIDTH-1] : q_q[0];
   assign busy         = (state_q == ST_BURST);
   assign done         = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised and directed bench for univ_shift_reg (WIDTH=8) against an
// arithmetic reference model of the register and burst sequencing.
module tb_univ_shift_reg;

   localparam int W = 8;
   localparam longint M = longint'(1) << W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] pin;
   logic         ser_in;
   logic         dir;
   logic         start;
   logic [W-1:0] pout;
   logic         ser_out;
   logic         busy;
   logic         done;

   logic [W-1:0] m_q;
   logic         m_dir;
   logic         m_busy;
   logic         m_done;
   int           m_left;

   int n_chk  = 0;
   int n_pass = 0;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode         (mode),
      .parallel_in  (pin),
      .ser_in       (ser_in),
      .dir          (dir),
      .start        (start),
      .parallel_out (pout),
      .ser_out      (ser_out),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_q = '0; m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
   endtask

   // one enabled-or-not clock edge of the reference behaviour
   task automatic model_edge();
      longint v;
      logic   nd;
      v  = longint'(m_q);
      nd = 1'b0;
      if (en) begin
         if (m_busy) begin
            if (m_dir) v = (v * 2 + longint'(ser_in)) % M;
            else       v = v / 2 + longint'(ser_in) * (M / 2);
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               nd     = 1'b1;
            end
         end else if (start) begin
            v      = longint'(pin);
            m_dir  = dir;
            m_left = W;
            m_busy = 1'b1;
         end else begin
            case (mode)
               3'd1: v = (v * 2 + longint'(ser_in)) % M;
               3'd2: v = v / 2 + longint'(ser_in) * (M / 2);
               3'd3: v = longint'(pin);
               3'd4: v = (v * 2) % M + v / (M / 2);
               3'd5: v = v / 2 + (v % 2) * (M / 2);
               3'd6: v = 0;
`ifdef USR_ARITH_SHIFT_EN
               3'd7: v = v / 2 + ((v >= M / 2) ? M / 2 : 0);
`endif
               default: v = v;
            endcase
         end
      end
      m_q    = W'(v);
      m_done = nd;
   endtask

   task automatic check_outs();
      check("pout", 64'(pout), 64'(m_q));
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("ser_out", 64'(ser_out), 64'(m_dir ? m_q[W-1] : m_q[0]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic mode_step(input logic [7:0] init, input logic [2:0] md,
                            input logic [7:0] exp, input string tag);
      mode = 3'd3; pin = init; tick();
      mode = md; ser_in = 1'b1; pin = 8'h3C; tick();
      check(tag, 64'(pout), 64'(exp));
   endtask

   // one burst of 0xA5 while feeding 0xC3; optional 3-cycle stall after 3 edges
   task automatic burst_test(input logic d, input logic stall, input string tag);
      logic [7:0] seq;
      logic [7:0] pat;
      int k;
      int lat;
      logic stalled;
      seq = 8'b1010_0101;
      pat = 8'hC3;
      pin = 8'hA5; dir = d; start = 1'b1; en = 1'b1;
      tick();
      start = 1'b0;
      k = 0; lat = 0;
      while (!done && lat < 20) begin
         stalled = stall && (lat >= 3) && (lat < 6);
         en = !stalled;
         if (k < 8) begin
            check({tag, "_seq"}, 64'(ser_out), 64'(seq[k]));
            ser_in = d ? pat[W-1-k] : pat[k];
         end
         check({tag, "_busy"}, 64'(busy), 64'd1);
         tick();
         lat++;
         if (!stalled) k++;
      end
      en = 1'b1;
      check({tag, "_lat"}, 64'(lat), stall ? 64'd11 : 64'd8);
      check({tag, "_final"}, 64'(pout), 64'hC3);
      mode = 3'd0;
      tick();
      check({tag, "_done_clr"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; en = 1'b0; mode = 3'd0; pin = '0; ser_in = 1'b0; dir = 1'b0; start = 1'b0;
      model_reset();
      #3;
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;

      // mode walk from 0xB4
      mode_step(8'hB4, 3'd1, 8'h69, "shl");
      mode_step(8'hB4, 3'd2, 8'hDA, "shr");
      mode_step(8'hB4, 3'd4, 8'h69, "rotl");
      mode_step(8'hB4, 3'd5, 8'h5A, "rotr");
      mode_step(8'hB4, 3'd6, 8'h00, "clear");
      mode_step(8'hB4, 3'd3, 8'h3C, "load");
      mode_step(8'hB4, 3'd0, 8'hB4, "hold");
`ifdef USR_ARITH_SHIFT_EN
      mode_step(8'h96, 3'd7, 8'hCB, "mode7");
`else
      mode_step(8'h96, 3'd7, 8'h96, "mode7");
`endif

      burst_test(1'b0, 1'b0, "lsb");
      burst_test(1'b1, 1'b1, "msb_stall");

      // start re-pulsed while busy, then back-to-back burst from the done cycle
      pin = 8'hA5; dir = 1'b0; start = 1'b1; tick();
      pin = 8'hFF; dir = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         ser_in = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      check("ignore_lat", 64'(lat), 64'd5);
      pin = 8'h5A; start = 1'b1; tick();
      check("b2b_busy", 64'(busy), 64'd1);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         ser_in = 1'($urandom_range(0, 1));
         tick();
         lat++;
      end
      check("b2b_lat", 64'(lat), 64'd8);

      // asynchronous reset mid-burst
      pin = 8'h77; start = 1'b1; tick();
      start = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_pout", 64'(pout), 64'h00);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mode  = 3'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_no_done", 64'(done), 64'd0);
      end

      // randomised traffic
      for (int i = 0; i < 400; i++) begin
         en     = ($urandom_range(0, 9) != 0);
         start  = ($urandom_range(0, 7) == 0);
         mode   = 3'($urandom_range(0, 7));
         dir    = 1'($urandom_range(0, 1));
         ser_in = 1'($urandom_range(0, 1));
         pin    = W'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
